exec_result_stage: RTL

- Stage directly downstream of the ALU.
- Registers the ALU result and flags and resolves beq/blt/bgt.
- Runs load/store memory transactions with a request/ack handshake.
- Issues register-file writebacks.
- Valid/ready handshake on its input; accepts one instruction at a time.

---
 rtl/exec_result_stage.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/exec_result_stage.sv
// Execute/result stage: registers ALU flags, resolves branches, runs load/store
// handshakes and issues writebacks. Optional memory watchdog under MEM_TIMEOUT_EN.
module exec_result_stage #(
    parameter int REG_AW         = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        aluop,
    input  logic [15:0]       alu_out,
    input  logic              zero,
    input  logic              neg,
    input  logic              ovf,
    input  logic [REG_AW-1:0] rd,
    input  logic [15:0]       st_data,
    input  logic [15:0]       br_target,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [15:0]       wb_data,
    output logic              br_taken,
    output logic [15:0]       br_pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [15:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [2:0]        flags,
    output logic              mem_err
);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB} state_e;

    localparam logic [3:0] OP_LAST_ALU = 4'd8;
    localparam logic [3:0] OP_BEQ      = 4'd9;
    localparam logic [3:0] OP_BLT      = 4'd10;
    localparam logic [3:0] OP_BGT      = 4'd11;
    localparam logic [3:0] OP_LOAD     = 4'd12;
    localparam logic [3:0] OP_STORE    = 4'd13;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..256");
    end

    state_e              state_q, state_d;
    logic [2:0]          flags_q, flags_d;
    logic                wb_en_q, wb_en_d;
    logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;
    logic [15:0]         wb_data_q, wb_data_d;
    logic                br_taken_q, br_taken_d;
    logic [15:0]         br_pc_q, br_pc_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [15:0]         mem_addr_q, mem_addr_d;
    logic [15:0]         mem_wdata_q, mem_wdata_d;
    logic                accept;
    logic                taken;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       mem_err_q, mem_err_d;
`endif

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        taken = 1'b0;
        case (aluop)
            OP_BEQ:  taken = zero;
            OP_BLT:  taken = neg;
            OP_BGT:  taken = !neg && !zero;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        flags_d     = flags_q;
        wb_en_d     = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        br_taken_d  = 1'b0;
        br_pc_d     = br_pc_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_d   = '0;
        mem_err_d   = mem_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (aluop <= OP_BGT) flags_d = {ovf, neg, zero};
                    if (aluop <= OP_LAST_ALU) begin
                        wb_en_d   = 1'b1;
                        wb_addr_d = rd;
                        wb_data_d = alu_out;
                    end else if (aluop <= OP_BGT) begin
                        br_taken_d = taken;
                        if (taken) br_pc_d = br_target;
                    end else if (aluop == OP_LOAD || aluop == OP_STORE) begin
                        state_d    = S_MEM;
                        mem_req_d  = 1'b1;
                        mem_we_d   = (aluop == OP_STORE);
                        mem_addr_d = alu_out;
                        if (aluop == OP_STORE) mem_wdata_d = st_data;
                        else                   wb_addr_d   = rd;
                    end
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        wb_en_d   = 1'b1;
                        wb_data_d = mem_rdata;
                        state_d   = S_WB;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                // An ack arriving on the final watchdog cycle takes priority over the timeout.
                else if (tmo_cnt_q == TIMEOUT_LAST) begin
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            flags_q     <= '0;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            br_taken_q  <= 1'b0;
            br_pc_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            wb_en_q     <= wb_en_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            br_taken_q  <= br_taken_d;
            br_pc_q     <= br_pc_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end
    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign flags     = flags_q;
    assign wb_en     = wb_en_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign br_taken  = br_taken_q;
    assign br_pc     = br_pc_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
